axi_slave_wr_resp: RTL and testbench

Slave-side AXI write responder: accepts one AW request and its W burst, converts each data beat to a word-addressed memory write strobe, then returns a single write response (BVALID/BID/BRESP) to the interconnect. It sits at each memory-mapped slave port and produces the per-slave B-channel signals that the interconnect's B-channel arbiter routes back to the issuing master. One transaction is in flight at a time.

---
 rtl/axi_slave_pkg.sv | 24 ++
 rtl/axi_burst_addr_gen.sv | 28 ++
 rtl/axi_slave_wr_resp.sv | 133 +++++++++++++
 tb/tb_axi_slave_wr_resp.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// Shared types and constants for the AXI slave write-response path.
package axi_slave_pkg;

  localparam int unsigned ID_W   = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [2:0] SIZE_WORD = 3'b010;

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst word-address generator: load on AW, step per beat, FIXED holds, INCR wraps modulo memory size.
module axi_burst_addr_gen #(
  parameter int unsigned ADDR_BITS = 14
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_addr,
  input  logic                 load_fixed,
  input  logic                 step,
  output logic [ADDR_BITS-1:0] addr
);

  logic fixed_q;

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      addr    <= '0;
      fixed_q <= 1'b0;
    end else if (load) begin
      addr    <= load_addr;
      fixed_q <= load_fixed;
    end else if (step && !fixed_q) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/axi_slave_wr_resp.sv
// Slave-side AXI write responder: one AW + W burst -> memory strobes -> single B response.
// Optional address window check enabled by defining AXI_WR_ADDR_CHECK_EN.
module axi_slave_wr_resp
  import axi_slave_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_0000,
  parameter int unsigned MEM_ADDR_BITS = 14
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic [ID_W-1:0]          AWID,
  input  logic [ADDR_W-1:0]        AWADDR,
  input  logic [LEN_W-1:0]         AWLEN,
  input  logic [2:0]               AWSIZE,
  input  logic [1:0]               AWBURST,
  input  logic                     AWVALID,
  output logic                     AWREADY,
  input  logic [DATA_W-1:0]        WDATA,
  input  logic [3:0]               WSTRB,
  input  logic                     WLAST,
  input  logic                     WVALID,
  output logic                     WREADY,
  output logic [ID_W-1:0]          BID,
  output logic [1:0]               BRESP,
  output logic                     BVALID,
  input  logic                     BREADY,
  output logic                     mem_cs,
  output logic [3:0]               mem_web,
  output logic [MEM_ADDR_BITS-1:0] mem_addr,
  output logic [DATA_W-1:0]        mem_di
);

  wr_state_t  state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat_cnt;
  logic             aw_err;
  logic             len_err;
  logic             range_err;
  logic             aw_hs;
  logic             beat;
  logic             wr_en;
  logic [MEM_ADDR_BITS-1:0] cur_addr;

`ifdef AXI_WR_ADDR_CHECK_EN
  localparam logic [32:0] WIN_BYTES = 33'd4 << MEM_ADDR_BITS;
  logic [31:0] aw_offset;
  assign aw_offset = AWADDR - BASE_ADDR;
  assign range_err = (AWADDR < BASE_ADDR) || ({1'b0, aw_offset} >= WIN_BYTES);
`else
  assign range_err = 1'b0;
`endif

  assign aw_hs = AWVALID && AWREADY;
  assign beat  = WVALID && WREADY;
  // Address/size errors gate the memory port; WLAST mismatches only affect BRESP.
  assign wr_en = beat && !aw_err;

  assign mem_cs   = wr_en;
  assign mem_web  = wr_en ? WSTRB : '0;
  assign mem_di   = wr_en ? WDATA : '0;
  assign mem_addr = cur_addr;

  axi_burst_addr_gen #(
    .ADDR_BITS (MEM_ADDR_BITS)
  ) u_addr_gen (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .load       (aw_hs),
    .load_addr  (MEM_ADDR_BITS'((AWADDR - BASE_ADDR) >> 2)),
    .load_fixed (AWBURST == BURST_FIXED),
    .step       (beat),
    .addr       (cur_addr)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state    <= IDLE;
      AWREADY  <= 1'b1;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
      BID      <= '0;
      len_q    <= '0;
      beat_cnt <= '0;
      aw_err   <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_hs) begin
            BID      <= AWID;
            len_q    <= AWLEN;
            beat_cnt <= '0;
            aw_err   <= (AWSIZE != SIZE_WORD) || range_err;
            len_err  <= 1'b0;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b1;
            state    <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (WLAST) begin
              WREADY <= 1'b0;
              BVALID <= 1'b1;
              BRESP  <= (aw_err || len_err || (beat_cnt != len_q)) ? RESP_SLVERR : RESP_OKAY;
              state  <= RESP;
            end else begin
              // Overrun past AWLEN keeps accepting beats until WLAST; counter saturates.
              if (beat_cnt == len_q) len_err <= 1'b1;
              if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        RESP: begin
          if (BREADY) begin
            BVALID  <= 1'b0;
            BRESP   <= RESP_OKAY;
            AWREADY <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          AWREADY <= 1'b1;
          WREADY  <= 1'b0;
          BVALID  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_wr_resp.sv
// Directed self-checking bench for axi_slave_wr_resp (default parameters, BASE_ADDR = 0).
module tb_axi_slave_wr_resp;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic        mem_cs;
  logic [3:0]  mem_web;
  logic [13:0] mem_addr;
  logic [31:0] mem_di;

  int checks = 0;
  int errors = 0;

  always #5 ACLK = ~ACLK;

  axi_slave_wr_resp #(
    .BASE_ADDR     (32'h0000_0000),
    .MEM_ADDR_BITS (14)
  ) dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .AWID     (AWID),
    .AWADDR   (AWADDR),
    .AWLEN    (AWLEN),
    .AWSIZE   (AWSIZE),
    .AWBURST  (AWBURST),
    .AWVALID  (AWVALID),
    .AWREADY  (AWREADY),
    .WDATA    (WDATA),
    .WSTRB    (WSTRB),
    .WLAST    (WLAST),
    .WVALID   (WVALID),
    .WREADY   (WREADY),
    .BID      (BID),
    .BRESP    (BRESP),
    .BVALID   (BVALID),
    .BREADY   (BREADY),
    .mem_cs   (mem_cs),
    .mem_web  (mem_web),
    .mem_addr (mem_addr),
    .mem_di   (mem_di)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic do_aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                       input logic [2:0] size, input logic [1:0] burst);
    AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
    #1;
    chk("aw_ready", AWREADY, 1);
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic do_beat(input string tag, input logic [31:0] data, input logic [3:0] strb,
                         input logic last, input logic exp_cs, input logic [13:0] exp_addr);
    WDATA = data; WSTRB = strb; WLAST = last; WVALID = 1'b1;
    #1;
    chk({tag, "_wready"}, WREADY, 1);
    chk({tag, "_cs"}, mem_cs, exp_cs);
    if (exp_cs) begin
      chk({tag, "_addr"}, mem_addr, exp_addr);
      chk({tag, "_web"}, mem_web, strb);
      chk({tag, "_di"}, mem_di, data);
    end else begin
      chk({tag, "_web0"}, mem_web, 0);
    end
    tick();
    WVALID = 1'b0;
    WLAST  = 1'b0;
  endtask

  task automatic gap(input string tag);
    WVALID = 1'b0;
    #1;
    chk({tag, "_gap_cs"}, mem_cs, 0);
    tick();
  endtask

  // Response must be present right after the last beat; BREADY is high so it retires next edge.
  task automatic expect_b(input string tag, input logic [7:0] id, input logic [1:0] resp);
    chk({tag, "_bvalid"}, BVALID, 1);
    chk({tag, "_bid"}, BID, id);
    chk({tag, "_bresp"}, BRESP, resp);
    chk({tag, "_awready_resp"}, AWREADY, 0);
    tick();
    chk({tag, "_bvalid_clr"}, BVALID, 0);
    chk({tag, "_awready_idle"}, AWREADY, 1);
  endtask

  initial begin
    ARESETn = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = 3'b010; AWBURST = 2'b01; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    tick();
    tick();
    ARESETn = 1'b1;
    #1;
    chk("rst_awready", AWREADY, 1);
    chk("rst_wready", WREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_bid", BID, 0);
    chk("rst_cs", mem_cs, 0);
    chk("rst_web", mem_web, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_di", mem_di, 0);

    // WVALID while idle is not accepted
    WVALID = 1'b1; WDATA = 32'h1234_5678; WSTRB = 4'hF; WLAST = 1'b1;
    #1;
    chk("idle_w_wready", WREADY, 0);
    chk("idle_w_cs", mem_cs, 0);
    tick();
    WVALID = 1'b0; WLAST = 1'b0;
    chk("idle_w_bvalid", BVALID, 0);

    // Single beat: addr 0x10 -> word 4
    do_aw(8'h82, 32'h0000_0010, 4'd0, 3'b010, 2'b01);
    chk("t1_awready_data", AWREADY, 0);
    do_beat("t1_b0", 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 14'd4);
    expect_b("t1", 8'h82, 2'b00);

    // INCR AWLEN=3 from word 5 with gapped WVALID
    do_aw(8'h13, 32'h0000_0014, 4'd3, 3'b010, 2'b01);
    do_beat("t2_b0", 32'hA000_0000, 4'hF, 1'b0, 1'b1, 14'd5);
    gap("t2_g0");
    do_beat("t2_b1", 32'hA000_0001, 4'h3, 1'b0, 1'b1, 14'd6);
    gap("t2_g1");
    do_beat("t2_b2", 32'hA000_0002, 4'hC, 1'b0, 1'b1, 14'd7);
    gap("t2_g2");
    chk("t2_no_early_b", BVALID, 0);
    do_beat("t2_b3", 32'hA000_0003, 4'hF, 1'b1, 1'b1, 14'd8);
    expect_b("t2", 8'h13, 2'b00);

    // FIXED AWLEN=1 at word 16
    do_aw(8'h21, 32'h0000_0040, 4'd1, 3'b010, 2'b00);
    do_beat("t3_b0", 32'h0000_00AA, 4'h1, 1'b0, 1'b1, 14'd16);
    do_beat("t3_b1", 32'hBB00_0000, 4'h8, 1'b1, 1'b1, 14'd16);
    expect_b("t3", 8'h21, 2'b00);

    // Early WLAST: AWLEN=3 ends after beat 2
    do_aw(8'h34, 32'h0000_0000, 4'd3, 3'b010, 2'b01);
    do_beat("t4_b0", 32'h0000_0001, 4'hF, 1'b0, 1'b1, 14'd0);
    do_beat("t4_b1", 32'h0000_0002, 4'hF, 1'b1, 1'b1, 14'd1);
    expect_b("t4", 8'h34, 2'b10);

    // Late WLAST: AWLEN=0 but WLAST on beat 2
    do_aw(8'h45, 32'h0000_0100, 4'd0, 3'b010, 2'b01);
    do_beat("t5_b0", 32'h0000_0003, 4'hF, 1'b0, 1'b1, 14'd64);
    chk("t5_still_data", BVALID, 0);
    do_beat("t5_b1", 32'h0000_0004, 4'hF, 1'b1, 1'b1, 14'd65);
    expect_b("t5", 8'h45, 2'b10);

    // Bad AWSIZE: beats accepted, memory suppressed, SLVERR
    do_aw(8'h56, 32'h0000_0020, 4'd0, 3'b001, 2'b01);
    do_beat("t6_b0", 32'hCAFE_0000, 4'hF, 1'b1, 1'b0, 14'd8);
    expect_b("t6", 8'h56, 2'b10);

    // Wrap at top of memory: word 16383 then 0
    do_aw(8'h67, 32'h0000_FFFC, 4'd1, 3'b010, 2'b01);
    do_beat("t7_b0", 32'h1111_1111, 4'hF, 1'b0, 1'b1, 14'd16383);
    do_beat("t7_b1", 32'h2222_2222, 4'hF, 1'b1, 1'b1, 14'd0);
    expect_b("t7", 8'h67, 2'b00);

    // One past the window, then BREADY stalled for 5 cycles
    do_aw(8'h78, 32'h0001_0000, 4'd0, 3'b010, 2'b01);
    BREADY = 1'b0;
`ifdef AXI_WR_ADDR_CHECK_EN
    do_beat("t8_b0", 32'h3333_3333, 4'hF, 1'b1, 1'b0, 14'd0);
`else
    do_beat("t8_b0", 32'h3333_3333, 4'hF, 1'b1, 1'b1, 14'd0);
`endif
    AWVALID = 1'b1; AWID = 8'hEE; AWADDR = 32'h0000_0004;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t8_stall_bvalid", BVALID, 1);
      chk("t8_stall_bid", BID, 8'h78);
`ifdef AXI_WR_ADDR_CHECK_EN
      chk("t8_stall_bresp", BRESP, 2'b10);
`else
      chk("t8_stall_bresp", BRESP, 2'b00);
`endif
      chk("t8_stall_awready", AWREADY, 0);
      tick();
    end
    AWVALID = 1'b0;
    BREADY = 1'b1;
    tick();
    chk("t8_bvalid_clr", BVALID, 0);
    chk("t8_awready", AWREADY, 1);

    // Reset asserted during beat 2 of 4: back to idle, no response
    do_aw(8'h89, 32'h0000_0200, 4'd3, 3'b010, 2'b01);
    do_beat("t9_b0", 32'h4444_4444, 4'hF, 1'b0, 1'b1, 14'd128);
    ARESETn = 1'b0;
    WVALID = 1'b1; WDATA = 32'h5555_5555; WSTRB = 4'hF; WLAST = 1'b0;
    #1;
    chk("t9_b1_cs", mem_cs, 1);
    chk("t9_b1_addr", mem_addr, 14'd129);
    tick();
    ARESETn = 1'b1;
    WVALID = 1'b0;
    #1;
    chk("t9_awready", AWREADY, 1);
    chk("t9_wready", WREADY, 0);
    chk("t9_bvalid", BVALID, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t9_no_b", BVALID, 0);
    end

    // Normal operation resumes after reset
    do_aw(8'h9A, 32'h0000_0008, 4'd0, 3'b010, 2'b01);
    do_beat("t10_b0", 32'h6666_6666, 4'h5, 1'b1, 1'b1, 14'd2);
    expect_b("t10", 8'h9A, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on total run time
  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
